// File: rtl/rv32_fetch_queue_stage.sv
// Instruction fetch stage: sequential fetch PC feeding a small prefetch queue
// that hands {pc, instr} entries to decode under a valid/ready handshake.

`ifndef RV_NOP
`define RV_NOP 32'h0000_0013
`endif

package rv32_fetch_queue_stage_pkg;

  typedef logic [31:0] rv32_word;

  typedef enum logic [3:0] {
    MEM_LB  = 4'd0,
    MEM_LH  = 4'd1,
    MEM_LW  = 4'd2,
    MEM_LBU = 4'd3,
    MEM_LHU = 4'd4,
    MEM_SB  = 4'd5,
    MEM_SH  = 4'd6,
    MEM_SW  = 4'd7
  } mem_op_t;

  typedef struct packed {
    rv32_word addr;
    mem_op_t  op;
  } memory_request_t;

  typedef struct packed {
    logic     ready;
    rv32_word data;
  } memory_response_t;

  typedef struct packed {
    rv32_word pc;
    rv32_word instr;
  } fetch_buffer_data_t;

endpackage

module rv32_fetch_queue_stage
  import rv32_fetch_queue_stage_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        redirect,
  input  rv32_word                    redirect_pc,
  input  logic                        decode_ready,
  output logic                        fetch_valid,
  output fetch_buffer_data_t          fetch_data,
  output logic                        stall,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        instr_req_valid,
  output memory_request_t             instr_request,
  input  memory_response_t            instr_response
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  rv32_word           fetch_pc;
  fetch_buffer_data_t storage [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic               push;
  logic               pop;
  logic               unused_redirect_lsbs;

  // Word-alignment bits of the redirect target are dropped.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Request issue and queue handshake qualifiers.
  always_comb begin
    instr_req_valid    = ~reset & ~redirect & (count < CW'(DEPTH));
    instr_request.addr = fetch_pc;
    instr_request.op   = MEM_LW;
    push               = instr_req_valid & instr_response.ready;
    pop                = fetch_valid & decode_ready;
  end

  // Decode-facing view of the queue head; a NOP bubble when empty.
  always_comb begin
    fetch_valid = (count != '0);
    stall       = ~fetch_valid;
    if (fetch_valid) begin
      fetch_data = storage[rd_ptr];
    end else begin
      fetch_data.pc    = fetch_pc;
      fetch_data.instr = `RV_NOP;
    end
  end

  // Queue storage write; push is already suppressed by reset and redirect.
  always_ff @(posedge clk) begin
    if (push) begin
      storage[wr_ptr] <= '{pc: fetch_pc, instr: instr_response.data};
    end
  end

  // Fetch PC, pointers and occupancy: reset > redirect > push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_rv32_fetch_queue_stage.sv
// Directed and randomised checks of rv32_fetch_queue_stage against a
// scoreboard queue of expected {pc, instr} entries and a bench-side fetch PC.

`ifndef RV_NOP
`define RV_NOP 32'h0000_0013
`endif

module tb_rv32_fetch_queue_stage;
  import rv32_fetch_queue_stage_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic               clk = 1'b0;
  logic               reset;
  logic               redirect;
  rv32_word           redirect_pc;
  logic               decode_ready;
  logic               fetch_valid;
  fetch_buffer_data_t fetch_data;
  logic               stall;
  logic [2:0]         count;
  logic               instr_req_valid;
  memory_request_t    instr_request;
  memory_response_t   instr_response;
  logic               bus_ready;

  int checks = 0;
  int errors = 0;

  fetch_buffer_data_t sb[$];
  rv32_word           m_pc;
  logic               known = 1'b0;

  always #5 clk = ~clk;

  // Memory returns the bit-inverse of the address so each word is unique.
  assign instr_response = {bus_ready, ~instr_request.addr};

  rv32_fetch_queue_stage #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .decode_ready    (decode_ready),
    .fetch_valid     (fetch_valid),
    .fetch_data      (fetch_data),
    .stall           (stall),
    .count           (count),
    .instr_req_valid (instr_req_valid),
    .instr_request   (instr_request),
    .instr_response  (instr_response)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic step(input logic rst, input logic rd, input rv32_word rpc,
                      input logic dr, input logic br);
    logic               exp_issue;
    logic               exp_pop;
    fetch_buffer_data_t e;
    @(negedge clk);
    reset        = rst;
    redirect     = rd;
    redirect_pc  = rpc;
    decode_ready = dr;
    bus_ready    = br;
    #1;
    exp_issue = !rst && !rd && (sb.size() < DEPTH);
    exp_pop   = (sb.size() != 0) && dr;
    if (known) begin
      chk("req_valid", 64'(instr_req_valid), 64'(exp_issue));
      chk("req_addr", 64'(instr_request.addr), 64'(m_pc));
      chk("req_op", 64'(instr_request.op), 64'(MEM_LW));
      chk("fetch_valid", 64'(fetch_valid), 64'(sb.size() != 0));
      chk("stall", 64'(stall), 64'(sb.size() == 0));
      chk("count", 64'(count), 64'(sb.size()));
      if (sb.size() != 0) begin
        chk("head", 64'(fetch_data), 64'(sb[0]));
      end else begin
        chk("empty_head", 64'(fetch_data), {m_pc, 32'(`RV_NOP)});
      end
    end
    if (rst) begin
      sb.delete();
      m_pc  = RESET_PC;
      known = 1'b1;
    end else if (rd) begin
      sb.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (exp_pop) void'(sb.pop_front());
      if (exp_issue && br) begin
        e.pc    = m_pc;
        e.instr = ~m_pc;
        sb.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; decode_ready = 1'b0; bus_ready = 1'b0;

    // Reset, then streaming with an always-ready bus and decode.
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);

    // Fill the queue with decode stalled, then drain.
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    chk("full_pc_held", 64'(instr_request.addr), 64'(32'h0000_0110));
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);

    // Bus stalls three cycles mid-stream.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // Redirect with three entries queued.
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 32'h0000_2003, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // Reset and redirect together: reset wins.
    step(1, 1, 32'h0000_4000, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("rst_over_redirect_pc", 64'(fetch_data.pc), 64'(RESET_PC));

    // Fetch PC wraps past the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // Reset with a full queue and a ready bus.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Randomised traffic with occasional redirects.
    for (int i = 0; i < 200; i++) begin
      step(0, ($urandom_range(0, 15) == 0), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_fetch_queue_stage.md
# rv32_fetch_queue_stage

Parametrised instruction fetch stage with its own fetch PC and a DEPTH-entry prefetch queue between the instruction bus and decode. It fetches sequentially while the queue has room, buffers returned words, and hands them to decode under a valid/ready handshake. A redirect flushes the queue and restarts fetch at a new PC. It sits between the instruction bus port and the decode stage.

## Interface

- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0

- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- redirect  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  32 (rv32_word)  new fetch PC; bits [1:0] ignored, treated as 0
- decode_ready  in  1  decode accepts the head entry this cycle
- fetch_valid  out  1  fetch_data holds a valid queued instruction
- fetch_data  out  fetch_buffer_data_t  head entry {pc, instr}
- stall  out  1  equals ~fetch_valid
- count  out  $clog2(DEPTH)+1  current queue occupancy
- instr_req_valid  out  1  instr_request is live this cycle
- instr_request  out  memory_request_t  addr = fetch_pc, op = MEM_LW
- instr_response  in  memory_response_t  ready = word returned this cycle, data = word

## Operation

- State: fetch_pc (32 b), storage[DEPTH] of {pc, instr}, rd_ptr, wr_ptr ($clog2(DEPTH) b each, wrap mod DEPTH), count.
- Issue: instr_req_valid = ~reset & ~redirect & (count < DEPTH). instr_request.addr = fetch_pc, op = MEM_LW, driven every cycle regardless of valid.
- Push: when instr_req_valid & instr_response.ready: storage[wr_ptr] <= {fetch_pc, instr_response.data}; wr_ptr++; fetch_pc <= fetch_pc + 4 (32-bit wrap, 0xFFFF_FFFC → 0).
- Bus not ready: nothing pushed, fetch_pc held, request repeats next cycle at same addr.
- Output: fetch_valid = (count != 0). Non-empty: fetch_data = storage[rd_ptr]. Empty: fetch_data.pc = fetch_pc, fetch_data.instr = `RV_NOP.
- Pop: when fetch_valid & decode_ready: rd_ptr++.
- count next = count + push − pop; push and pop in same cycle leave count unchanged.
- No bypass: word accepted from the bus is never visible to decode in the same cycle.
- Redirect: count, rd_ptr, wr_ptr <= 0; fetch_pc <= {redirect_pc[31:2], 2'b00}; no push, no request that cycle; any concurrent pop is discarded (decode must treat redirect as flush).
- Priority: reset > redirect > push/pop.
- Reset: fetch_pc <= RESET_PC, pointers and count <= 0.

## Timing

- Reset values (cycle after reset high): fetch_valid 0, stall 1, count 0, fetch_data = {RESET_PC, `RV_NOP}, instr_req_valid 0 while reset high, 1 the first cycle after release.
- Latency: bus ready at cycle N → entry at head with fetch_valid = 1 at N+1 (queue empty before).
- Redirect at cycle N → first request to redirect_pc at N+1; earliest valid output N+2.
- Throughput: 1 instr/cycle sustained with an always-ready bus and decode_ready held high; count settles at 1.
- Full (count = DEPTH): instr_req_valid 0; pop that cycle re-enables issue only at the next cycle.
- Reset asserted mid-stream: all queued entries dropped, no push on that edge even if bus ready.

## Test plan

- Reset release, bus always ready, decode_ready=1, RESET_PC=0x100 → fetch_valid from cycle 2, pc sequence 0x100,0x104,0x108…, one per cycle, count stays 1.
- decode_ready=0, bus ready, DEPTH=4 → count 1,2,3,4 then instr_req_valid=0, fetch_pc held at 0x110; raise decode_ready → entries 0x100..0x10C popped in order, fetch resumes at 0x110.
- Bus ready deasserted 3 cycles mid-stream → addr repeats same value 3 cycles, no gap in pc sequence, no duplicate entries.
- Redirect to 0x2003 with 3 entries queued → next cycle count=0, fetch_valid=0, instr_req_valid=1 with addr 0x2000; first output pc 0x2000 two cycles after redirect.
- Simultaneous redirect and reset → fetch_pc = RESET_PC, queue empty; fetch_pc at 0xFFFF_FFFC → next pushed pc 0x0000_0000.
- Empty queue → fetch_data.instr = `RV_NOP, stall=1; reset asserted with full queue → count 0 next cycle, no push on that edge.
